rst_decoder: RTL and testbench

Decodes a one-hot register-select code and a reset-enable strobe into four per-register clear strobes (row counter, column counter, current-value register, accumulator sum) for the CCSS processor datapath. It sits between the control unit and the datapath registers and gives each register its own clear line. A sticky error flag reports malformed select codes.

---
 rtl/rst_decoder.sv | 98 +++++++++
 tb/tb_rst_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rst_decoder.sv
// rst_decoder: one-hot register-select decoder for the CCSS datapath.
// Turns RST_sel/RST_en into per-register clear strobes (ROW, COL, CURR, SUM),
// their OR (rst_any), and a sticky sel_err flag for non-one-hot selects.
// Optional feature macro: RST_DECODER_REG_OUT_EN -- when defined, the strobes
// and rst_any come from flops (1-cycle latency); otherwise they are a pure
// combinational decode gated by rst_n. sel_err is registered in both builds.
module rst_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] RST_sel,
    input  logic       RST_en,
    input  logic       err_clr,
    output logic       rst_ROW,
    output logic       rst_COL,
    output logic       rst_CURR,
    output logic       rst_SUM,
    output logic       rst_any,
    output logic       sel_err
);

    // Bit positions of each target inside RST_sel.
    localparam int unsigned BIT_ROW  = 0;
    localparam int unsigned BIT_COL  = 1;
    localparam int unsigned BIT_CURR = 2;
    localparam int unsigned BIT_SUM  = 3;

    logic [3:0] strobe_dec;   // raw decode, before reset gating / registering
    logic       sel_bad;      // enabled access with a select that is not one-hot
    logic [3:0] strobe_out;   // strobes as actually driven on the ports
    logic       err_q;

    // Decode the enable and select into raw strobes; every selected bit fires,
    // even when the select is malformed.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        strobe_dec = '0;
        if (RST_en) begin
            strobe_dec = RST_sel;
        end
    end

    // A select is one-hot when it is non-zero and clearing its lowest set bit
    // leaves nothing behind.
    always_comb begin
        sel_bad = 1'b0;
        if (RST_en) begin
            sel_bad = (RST_sel == 4'b0000) || ((RST_sel & (RST_sel - 4'd1)) != 4'b0000);
        end
    end

    // Sticky error flag: clear has priority over a new error, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops are updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of block ordering.
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end else if (sel_bad) begin
            err_q <= 1'b1;
        end
    end

    assign sel_err = err_q;

`ifdef RST_DECODER_REG_OUT_EN
    logic [3:0] strobe_q;
    logic       any_q;

    // Registered strobes: sampled on clk, glitch-free, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= '0;
            any_q    <= 1'b0;
        end else begin
            strobe_q <= strobe_dec;
            any_q    <= |strobe_dec;
        end
    end

    assign strobe_out = strobe_q;
    assign rst_any    = any_q;
`else
    // Combinational strobes: zero latency, forced low while reset is held.
    always_comb begin
        strobe_out = strobe_dec & {4{rst_n}};
    end

    assign rst_any = |strobe_out;
`endif

    assign rst_ROW  = strobe_out[BIT_ROW];
    assign rst_COL  = strobe_out[BIT_COL];
    assign rst_CURR = strobe_out[BIT_CURR];
    assign rst_SUM  = strobe_out[BIT_SUM];

endmodule

// File: tb/tb_rst_decoder.sv
// Self-checking bench for rst_decoder: directed cases plus randomized stimulus
// against a behavioural model. Handles both builds via RST_DECODER_REG_OUT_EN.
module tb_rst_decoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] RST_sel;
    logic       RST_en;
    logic       err_clr;
    logic       rst_ROW, rst_COL, rst_CURR, rst_SUM, rst_any, sel_err;

    int vectors;
    int miscompares;

    // Model state: registered-output image and sticky error flag.
    logic [4:0] m_q;
    logic       m_err;

    rst_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RST_sel  (RST_sel),
        .RST_en   (RST_en),
        .err_clr  (err_clr),
        .rst_ROW  (rst_ROW),
        .rst_COL  (rst_COL),
        .rst_CURR (rst_CURR),
        .rst_SUM  (rst_SUM),
        .rst_any  (rst_any),
        .sel_err  (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the expected one and count it.
    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Observed outputs packed as {any, SUM, CURR, COL, ROW}.
    function automatic logic [4:0] outs_now();
        return {rst_any, rst_SUM, rst_CURR, rst_COL, rst_ROW};
    endfunction

    // Reference: each target's strobe is enable AND its select bit; any = OR.
    function automatic logic [4:0] model_outs(input logic [3:0] sel, input logic en);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i] = en && sel[i];
            if (r[i]) r[4] = 1'b1;
        end
        return r;
    endfunction

    // Apply one cycle of inputs at a negedge, check, advance to next negedge.
    task automatic step(input logic [3:0] sel, input logic en, input logic clr, input string tag);
        RST_sel = sel;
        RST_en  = en;
        err_clr = clr;
        #1;
`ifndef RST_DECODER_REG_OUT_EN
        check({tag, "_comb"}, {3'b0, outs_now()}, {3'b0, model_outs(sel, en)});
`endif
        if (clr) m_err = 1'b0;
        else if (en && $countones(sel) != 1) m_err = 1'b1;
        m_q = model_outs(sel, en);
        @(negedge clk);
`ifdef RST_DECODER_REG_OUT_EN
        check({tag, "_reg"}, {3'b0, outs_now()}, {3'b0, m_q});
`endif
        check({tag, "_err"}, {7'b0, sel_err}, {7'b0, m_err});
    endtask

    initial begin
        logic [3:0] rs;
        vectors     = 0;
        miscompares = 0;
        m_q   = '0;
        m_err = 1'b0;

        // Reset held with an active request: everything must stay low.
        rst_n   = 1'b0;
        RST_sel = 4'b1111;
        RST_en  = 1'b1;
        err_clr = 1'b0;
        #3;
        check("reset_outs", {3'b0, outs_now()}, 8'd0);
        check("reset_err",  {7'b0, sel_err},    8'd0);
        @(posedge clk);
        #1;
        check("reset_outs_clk", {3'b0, outs_now()}, 8'd0);
        RST_en  = 1'b0;
        RST_sel = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // One-hot pulses: each target alone, two cycles wide.
        for (int i = 0; i < 4; i++) begin
            rs = 4'b0001 << i;
            step(rs, 1'b1, 1'b0, "onehot_on");
            step(rs, 1'b1, 1'b0, "onehot_on2");
            step(rs, 1'b0, 1'b0, "onehot_off");
        end

        // Enable low: sweep every select, no strobe, no error.
        for (int s = 0; s < 16; s++) begin
            rs = 4'(s);
            step(rs, 1'b0, 1'b0, "sweep_idle");
        end

        // Two bits selected: both strobes, sticky error, then clear.
        step(4'b0011, 1'b1, 1'b0, "multi_sel");
        step(4'b0011, 1'b0, 1'b0, "multi_drop");
        step(4'b0000, 1'b0, 1'b0, "multi_hold");
        step(4'b0000, 1'b0, 1'b1, "multi_clr");
        step(4'b0000, 1'b0, 1'b0, "multi_after");

        // Empty select with clear in the same cycle: clear wins.
        step(4'b0000, 1'b1, 1'b1, "zero_clr");
        step(4'b0000, 1'b0, 1'b0, "zero_after");

        // Randomized traffic, occasional clears.
        for (int n = 0; n < 400; n++) begin
            rs = 4'($urandom_range(0, 15));
            step(rs, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), "rand");
        end

        // Mid-pulse reset on SUM: drops immediately, resumes after release.
        step(4'b1000, 1'b1, 1'b0, "sum_pulse");
        #3;
        check("sum_before_rst", {3'b0, outs_now()}, {3'b0, m_q});
        rst_n = 1'b0;
        m_q   = '0;
        m_err = 1'b0;
        #1;
        check("sum_in_rst", {3'b0, outs_now()}, 8'd0);
        check("err_in_rst", {7'b0, sel_err},    8'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
`ifdef RST_DECODER_REG_OUT_EN
        check("sum_release_wait", {3'b0, outs_now()}, 8'd0);
`else
        check("sum_release_now", {3'b0, outs_now()}, {3'b0, model_outs(4'b1000, 1'b1)});
`endif
        @(negedge clk);
        step(4'b1000, 1'b1, 1'b0, "sum_resume");
        step(4'b1000, 1'b0, 1'b0, "sum_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
